// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the i2c slave transfer controller.
// State encoding is exposed on the status port, so the values are fixed.
package i2c_slv_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        IDLE     = 2'd1,
        ACTIVE   = 2'd2,
        TIMEOUT  = 2'd3
    } slv_state_e;

    localparam int STS_RXOVF = 0;
    localparam int STS_TXUDR = 1;
    localparam int STS_TMO   = 2;
    localparam int STS_W     = 3;

endpackage

// File: rtl/i2c_slv_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and flush.
// A push to a full FIFO is accepted only when a pop frees a slot in the same cycle.
module i2c_slv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             S_AXI_ACLK,
    input  logic             slave_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign level     = wr_ptr - rd_ptr;
    // Head reads as zero when empty so no stale byte is ever visible.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/i2c_slave_xfer_ctrl.sv
// Sequences the i2c_slave core: RX/TX byte buffering, bus-idle address gating,
// SCL-stuck timeout detection and a single level interrupt.
module i2c_slave_xfer_ctrl
    import i2c_slv_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          IDLE_CYCLES    = 64,
    parameter logic [7:0]  FILL_BYTE      = 8'hFF,
    localparam int         L              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             S_AXI_ACLK,
    input  logic             slave_rst,
    input  logic             cfg_enable,
    input  logic [6:0]       cfg_own_addr,
    input  logic [L-1:0]     cfg_rx_thresh,
    input  logic [STS_W-1:0] cfg_irq_mask,
    input  logic [STS_W-1:0] sts_clear,
    input  logic             tx_push,
    input  logic [7:0]       tx_data,
    input  logic             rx_pop,
    output logic             tx_full,
    output logic             rx_empty,
    output logic [L-1:0]     tx_level,
    output logic [L-1:0]     rx_level,
    output logic [7:0]       rx_data,
    output logic [STS_W-1:0] sts_sticky,
    output logic [1:0]       state,
    output logic             irq,
    input  logic             scl_in,
    input  logic             core_data_valid,
    input  logic [7:0]       core_rdata,
    input  logic             core_tx_req,
    output logic [7:0]       core_wdata,
    output logic [6:0]       core_own_address
);

    localparam int LOW_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HIGH_W = $clog2(IDLE_CYCLES + 1);

    slv_state_e       cur_state;
    slv_state_e       nxt_state;
    logic [LOW_W-1:0] low_cnt;
    logic [HIGH_W-1:0] high_cnt;
    logic             low_hit;
    logic             high_hit;
    logic             timeout_evt;
    logic             core_evt_ok;
    logic             rx_push;
    logic             rx_full;
    logic             tx_pop;
    logic             tx_push_ok;
    logic             tx_empty;
    logic [7:0]       tx_head;
    logic [STS_W-1:0] sts_set;

    assign low_hit     = !scl_in && (low_cnt == LOW_W'(TIMEOUT_CYCLES - 1));
    assign high_hit    = scl_in && (high_cnt == HIGH_W'(IDLE_CYCLES - 1));
    assign core_evt_ok = (cur_state == IDLE) || (cur_state == ACTIVE);
    assign rx_push     = core_data_valid && core_evt_ok;
    assign tx_pop      = core_tx_req && core_evt_ok;
    assign tx_push_ok  = tx_push && !tx_full;
    assign state       = cur_state;
    assign core_wdata  = tx_empty ? FILL_BYTE : tx_head;

    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst) cur_state <= DISABLED;
        else           cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state   = cur_state;
        timeout_evt = 1'b0;
        case (cur_state)
            DISABLED: if (cfg_enable) nxt_state = IDLE;
            IDLE:     if (!scl_in || core_data_valid || core_tx_req) nxt_state = ACTIVE;
            ACTIVE: begin
                if (low_hit) begin
                    nxt_state   = TIMEOUT;
                    timeout_evt = 1'b1;
                end else if (high_hit) begin
                    nxt_state = IDLE;
                end
            end
            TIMEOUT:  if (high_hit) nxt_state = IDLE;
            default:  nxt_state = DISABLED;
        endcase
        // Disable overrides everything, including a coincident timeout.
        if (!cfg_enable) begin
            nxt_state   = DISABLED;
            timeout_evt = 1'b0;
        end
    end

    // Counters only run while a transfer is live and restart on every state change.
    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst) begin
            low_cnt  <= '0;
            high_cnt <= '0;
        end else if ((nxt_state != cur_state) || !((cur_state == ACTIVE) || (cur_state == TIMEOUT))) begin
            low_cnt  <= '0;
            high_cnt <= '0;
        end else if (scl_in) begin
            low_cnt  <= '0;
            high_cnt <= high_cnt + HIGH_W'(1);
        end else begin
            low_cnt  <= (cur_state == ACTIVE) ? low_cnt + LOW_W'(1) : '0;
            high_cnt <= '0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst)               core_own_address <= '0;
        else if (cur_state == IDLE)  core_own_address <= cfg_own_addr;
    end

    always_comb begin
        sts_set            = '0;
        sts_set[STS_RXOVF] = rx_push && rx_full && !rx_pop;
        sts_set[STS_TXUDR] = tx_pop && tx_empty;
        sts_set[STS_TMO]   = timeout_evt;
    end

    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst) sts_sticky <= '0;
        else           sts_sticky <= (sts_sticky & ~sts_clear) | sts_set;
    end

    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst) irq <= 1'b0;
        else           irq <= (cur_state != DISABLED) &&
                              (((cfg_rx_thresh != '0) && (rx_level >= cfg_rx_thresh)) ||
                               (|(sts_sticky & cfg_irq_mask)));
    end

    i2c_slv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .S_AXI_ACLK (S_AXI_ACLK),
        .slave_rst  (slave_rst),
        .push       (rx_push),
        .push_data  (core_rdata),
        .pop        (rx_pop),
        .flush      (1'b0),
        .head_data  (rx_data),
        .level      (rx_level),
        .full       (rx_full),
        .empty      (rx_empty)
    );

    i2c_slv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .S_AXI_ACLK (S_AXI_ACLK),
        .slave_rst  (slave_rst),
        .push       (tx_push_ok),
        .push_data  (tx_data),
        .pop        (tx_pop),
        .flush      (timeout_evt),
        .head_data  (tx_head),
        .level      (tx_level),
        .full       (tx_full),
        .empty      (tx_empty)
    );

endmodule

// File: tb/tb_i2c_slave_xfer_ctrl.sv
// Scoreboard bench for i2c_slave_xfer_ctrl: random FIFO traffic against a queue model,
// plus directed address-freeze, timeout, mid-transfer reset and disable scenarios.
module tb_i2c_slave_xfer_ctrl;
    import i2c_slv_pkg::*;

    localparam int         DEPTH = 8;
    localparam int         TMO   = 200;
    localparam int         IDL   = 16;
    localparam int         L     = $clog2(DEPTH) + 1;
    localparam logic [7:0] FILL  = 8'hFF;

    logic         S_AXI_ACLK = 1'b0;
    logic         slave_rst;
    logic         cfg_enable;
    logic [6:0]   cfg_own_addr;
    logic [L-1:0] cfg_rx_thresh;
    logic [2:0]   cfg_irq_mask;
    logic [2:0]   sts_clear;
    logic         tx_push;
    logic [7:0]   tx_data;
    logic         rx_pop;
    logic         tx_full;
    logic         rx_empty;
    logic [L-1:0] tx_level;
    logic [L-1:0] rx_level;
    logic [7:0]   rx_data;
    logic [2:0]   sts_sticky;
    logic [1:0]   state;
    logic         irq;
    logic         scl_in;
    logic         core_data_valid;
    logic [7:0]   core_rdata;
    logic         core_tx_req;
    logic [7:0]   core_wdata;
    logic [6:0]   core_own_address;

    typedef struct {
        bit         has;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_rx_q[$];
    exp_t       exp_tx_q[$];
    logic [7:0] rx_model[$];
    logic [7:0] tx_model[$];
    logic [2:0] sticky_model;
    bit         irq_pending;
    int         exp_rx_level;
    int         exp_tx_level;
    logic [2:0] exp_sticky;
    bit         exp_irq;
    bit         model_on;
    int         n_cmp;
    int         n_err;

    i2c_slave_xfer_ctrl #(
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .IDLE_CYCLES(IDL), .FILL_BYTE(FILL)
    ) dut (
        .S_AXI_ACLK(S_AXI_ACLK), .slave_rst(slave_rst), .cfg_enable(cfg_enable),
        .cfg_own_addr(cfg_own_addr), .cfg_rx_thresh(cfg_rx_thresh), .cfg_irq_mask(cfg_irq_mask),
        .sts_clear(sts_clear), .tx_push(tx_push), .tx_data(tx_data), .rx_pop(rx_pop),
        .tx_full(tx_full), .rx_empty(rx_empty), .tx_level(tx_level), .rx_level(rx_level),
        .rx_data(rx_data), .sts_sticky(sts_sticky), .state(state), .irq(irq), .scl_in(scl_in),
        .core_data_valid(core_data_valid), .core_rdata(core_rdata), .core_tx_req(core_tx_req),
        .core_wdata(core_wdata), .core_own_address(core_own_address)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    task automatic quiesce();
        core_data_valid = 1'b0;
        core_tx_req     = 1'b0;
        rx_pop          = 1'b0;
        tx_push         = 1'b0;
        sts_clear       = 3'b000;
        scl_in          = 1'b1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"},    state, DISABLED);
        checkOutput({tag, "_rx_empty"}, rx_empty, 1);
        checkOutput({tag, "_tx_full"},  tx_full, 0);
        checkOutput({tag, "_rx_level"}, rx_level, 0);
        checkOutput({tag, "_tx_level"}, tx_level, 0);
        checkOutput({tag, "_rx_data"},  rx_data, 0);
        checkOutput({tag, "_sticky"},   sts_sticky, 0);
        checkOutput({tag, "_irq"},      irq, 0);
        checkOutput({tag, "_own_addr"}, core_own_address, 0);
        checkOutput({tag, "_wdata"},    core_wdata, FILL);
    endtask

    // One random cycle: decide inputs, record expectations from the pre-edge model, advance the model.
    task automatic applyStimulus(input int p_rxp, input int p_rxo, input int p_txp, input int p_txr);
        bit         push_rx, pop_rx, push_tx, req_tx;
        logic [7:0] drx, dtx;
        logic [2:0] clr, set;
        int         rsz, tsz;
        exp_t       e;
        push_rx = ($urandom_range(0, 99) < p_rxp);
        pop_rx  = ($urandom_range(0, 99) < p_rxo);
        push_tx = ($urandom_range(0, 99) < p_txp);
        req_tx  = ($urandom_range(0, 99) < p_txr);
        drx     = 8'($urandom);
        dtx     = 8'($urandom);
        clr     = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
        rsz     = rx_model.size();
        tsz     = tx_model.size();
        exp_rx_level = rsz;
        exp_tx_level = tsz;
        exp_sticky   = sticky_model;
        exp_irq      = irq_pending;
        irq_pending  = ((cfg_rx_thresh != 0) && (rsz >= int'(cfg_rx_thresh))) || (|(sticky_model & cfg_irq_mask));
        set = 3'b000;
        if (pop_rx) begin
            e.has  = (rsz > 0);
            e.data = (rsz > 0) ? rx_model[0] : 8'h00;
            exp_rx_q.push_back(e);
            if (rsz > 0) void'(rx_model.pop_front());
        end
        if (push_rx) begin
            if (rsz == DEPTH && !pop_rx) set[0] = 1'b1;
            else                         rx_model.push_back(drx);
        end
        if (req_tx) begin
            e.has  = (tsz > 0);
            e.data = (tsz > 0) ? tx_model[0] : 8'h00;
            exp_tx_q.push_back(e);
            if (tsz > 0) void'(tx_model.pop_front());
            else         set[1] = 1'b1;
        end
        if (push_tx && tsz < DEPTH) tx_model.push_back(dtx);
        sticky_model = (sticky_model & ~clr) | set;
        core_data_valid = push_rx;
        core_rdata      = drx;
        rx_pop          = pop_rx;
        tx_push         = push_tx;
        tx_data         = dtx;
        core_tx_req     = req_tx;
        sts_clear       = clr;
        scl_in          = ($urandom_range(0, 3) != 0);
    endtask

    // Monitor: compares delivered bytes against the scoreboard queues and status against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge S_AXI_ACLK);
            if (rx_pop) begin
                if (exp_rx_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("[TB] FAIL rx_pop_scoreboard: got pop, expected no pop");
                end else begin
                    e = exp_rx_q.pop_front();
                    if (e.has) begin
                        checkOutput("rx_data", rx_data, e.data);
                        checkOutput("rx_empty_on_pop", rx_empty, 0);
                    end else begin
                        checkOutput("rx_empty_on_pop", rx_empty, 1);
                    end
                end
            end
            if (core_tx_req) begin
                if (exp_tx_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("[TB] FAIL tx_req_scoreboard: got request, expected none");
                end else begin
                    e = exp_tx_q.pop_front();
                    checkOutput("core_wdata", core_wdata, e.has ? e.data : FILL);
                end
            end
            if (model_on) begin
                checkOutput("rx_level", rx_level, exp_rx_level);
                checkOutput("tx_level", tx_level, exp_tx_level);
                checkOutput("rx_empty", rx_empty, exp_rx_level == 0);
                checkOutput("tx_full",  tx_full,  exp_tx_level == DEPTH);
                checkOutput("sticky",   sts_sticky, exp_sticky);
                checkOutput("irq",      irq, exp_irq);
            end
        end
    end

    initial begin
        int p_rxp, p_rxo, p_txp, p_txr;
        n_cmp = 0; n_err = 0; model_on = 0;
        sticky_model = 3'b000; irq_pending = 0;
        slave_rst = 1'b1; cfg_enable = 1'b0; cfg_own_addr = 7'h00;
        cfg_rx_thresh = '0; cfg_irq_mask = 3'b000; tx_data = 8'h00; core_rdata = 8'h00;
        quiesce();
        repeat (3) tick();
        checkReset("por");

        slave_rst = 1'b0;
        tick();
        checkOutput("state_disabled", state, DISABLED);
        cfg_enable = 1'b1; cfg_own_addr = 7'h2A;
        tick(); tick();
        checkOutput("state_idle", state, IDLE);
        checkOutput("own_addr_load", core_own_address, 7'h2A);
        checkOutput("irq_idle", irq, 0);

        // Random traffic: first segments force overflow and underrun, later ones are free-running.
        for (int seg = 0; seg < 5; seg++) begin
            case (seg)
                0:       begin p_rxp = 80; p_rxo = 10; p_txp = 10; p_txr = 60; end
                1:       begin p_rxp = 10; p_rxo = 70; p_txp = 80; p_txr = 10; end
                4:       begin p_rxp = 0;  p_rxo = 100; p_txp = 0; p_txr = 100; end
                default: begin
                    p_rxp = $urandom_range(10, 90); p_rxo = $urandom_range(10, 90);
                    p_txp = $urandom_range(10, 90); p_txr = $urandom_range(10, 90);
                end
            endcase
            cfg_rx_thresh = L'($urandom_range(0, DEPTH));
            cfg_irq_mask  = 3'($urandom);
            model_on = 1;
            for (int i = 0; i < ((seg == 4) ? 2 * DEPTH + 4 : 300); i++) begin
                applyStimulus(p_rxp, p_rxo, p_txp, p_txr);
                tick();
            end
        end
        applyStimulus(0, 0, 0, 0);
        tick();
        model_on = 0;
        quiesce();
        checkOutput("rx_scoreboard_drained", exp_rx_q.size(), 0);
        checkOutput("tx_scoreboard_drained", exp_tx_q.size(), 0);

        // Address changes are held off while a transfer is active.
        sts_clear = 3'b111; cfg_irq_mask = 3'b000; cfg_rx_thresh = '0;
        tick();
        sts_clear = 3'b000;
        repeat (IDL + 2) tick();
        checkOutput("pre_freeze_state", state, IDLE);
        scl_in = 1'b0;
        tick();
        scl_in = 1'b1; cfg_own_addr = 7'h30;
        checkOutput("freeze_active", state, ACTIVE);
        repeat (IDL - 1) tick();
        checkOutput("freeze_hold_state", state, ACTIVE);
        checkOutput("freeze_hold_addr", core_own_address, 7'h2A);
        tick(); tick();
        checkOutput("freeze_release_state", state, IDLE);
        checkOutput("freeze_release_addr", core_own_address, 7'h30);

        // SCL held low long enough to trip the timeout.
        tx_push = 1'b1; tx_data = 8'hA5;
        tick();
        tx_data = 8'h3C;
        tick();
        tx_push = 1'b0; cfg_irq_mask = 3'b100;
        checkOutput("tmo_tx_level_pre", tx_level, 2);
        checkOutput("tmo_wdata_pre", core_wdata, 8'hA5);
        scl_in = 1'b0;
        repeat (TMO) tick();
        checkOutput("tmo_boundary_state", state, ACTIVE);
        tick();
        checkOutput("tmo_state", state, TIMEOUT);
        checkOutput("tmo_sticky", sts_sticky, 3'b100);
        checkOutput("tmo_tx_flushed", tx_level, 0);
        checkOutput("tmo_wdata_fill", core_wdata, FILL);
        tick();
        checkOutput("tmo_irq", irq, 1);
        scl_in = 1'b1;
        repeat (IDL - 1) tick();
        checkOutput("tmo_hold", state, TIMEOUT);
        tick();
        checkOutput("tmo_exit", state, IDLE);
        sts_clear = 3'b100;
        tick();
        sts_clear = 3'b000;
        checkOutput("tmo_clear", sts_sticky, 0);
        tick(); tick();
        checkOutput("tmo_irq_clear", irq, 0);

        // Asynchronous reset in the middle of a transfer.
        scl_in = 1'b0; core_data_valid = 1'b1; core_rdata = 8'h5A;
        tick();
        core_data_valid = 1'b0; tx_push = 1'b1; tx_data = 8'h77;
        tick();
        tx_push = 1'b0;
        checkOutput("mid_state", state, ACTIVE);
        checkOutput("mid_rx_data", rx_data, 8'h5A);
        checkOutput("mid_tx_level", tx_level, 1);
        slave_rst = 1'b1;
        #2;
        checkReset("mid_rst");
        tick();
        scl_in = 1'b1; slave_rst = 1'b0;
        tick();

        // Disable: core events are ignored.
        cfg_enable = 1'b0;
        tick();
        checkOutput("dis_state", state, DISABLED);
        core_data_valid = 1'b1; core_rdata = 8'h99;
        tick();
        core_data_valid = 1'b0;
        tick();
        checkOutput("dis_rx_level", rx_level, 0);
        checkOutput("dis_irq", irq, 0);

        @(negedge S_AXI_ACLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
